// File: rtl/compare_pkg.sv
// Shared types and sizing helpers for the digit-serial magnitude comparator.
package compare_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Result codes are {gt, eq, lt}; CMP_NONE marks "no difference stored yet".
  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  function automatic int num_digits(input int cmp_w, input int dig_w);
    return (dig_w > 0) ? (cmp_w / dig_w) : 1;
  endfunction

  function automatic int cnt_width(input int nd);
    return $clog2(nd + 1);
  endfunction

  function automatic int idx_width(input int nd);
    return (nd > 1) ? $clog2(nd) : 1;
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Combinational unsigned compare of one digit, producing a one-hot {gt,eq,lt} code.
module digit_compare
  import compare_pkg::*;
#(
  parameter int DIGIT_WIDTH = 2
) (
  input  logic [DIGIT_WIDTH-1:0] x,
  input  logic [DIGIT_WIDTH-1:0] y,
  output logic [2:0]             code
);

  // Classify the digit pair.
  always_comb begin
    code = CMP_EQ;
    if (x > y) begin
      code = CMP_GT;
    end else if (x == y) begin
      code = CMP_EQ;
    end else begin
      code = CMP_LT;
    end
  end

endmodule

// File: rtl/compare_serial_n.sv
// Digit-serial MSB-first magnitude comparator with start/busy/done handshake,
// optional signed mode and optional early exit on the first differing digit.
module compare_serial_n
  import compare_pkg::*;
#(
  parameter int CMP_WIDTH   = 8,
  parameter int DIGIT_WIDTH = 2,
  parameter bit EARLY_EXIT  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [CMP_WIDTH-1:0] a,
  input  logic [CMP_WIDTH-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 greater,
  output logic                 equal,
  output logic                 smaller,
  output logic [cnt_width(num_digits(CMP_WIDTH, DIGIT_WIDTH))-1:0] digits_used
);

  localparam int NUM_DIGITS = num_digits(CMP_WIDTH, DIGIT_WIDTH);
  localparam int CNT_W      = cnt_width(NUM_DIGITS);
  localparam int IDX_W      = idx_width(NUM_DIGITS);

  localparam logic [IDX_W-1:0]     IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]     IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0]     IDX_TOP   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]     CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [CMP_WIDTH-1:0] OP_ZERO   = {CMP_WIDTH{1'b0}};
  localparam logic [CMP_WIDTH-1:0] SIGN_MASK = {1'b1, {(CMP_WIDTH-1){1'b0}}};

  if ((CMP_WIDTH < 2) || (DIGIT_WIDTH < 1) || ((CMP_WIDTH % DIGIT_WIDTH) != 0)) begin : g_param_check
    $error("compare_serial_n: CMP_WIDTH must be >= 2 and a multiple of DIGIT_WIDTH");
  end

  state_t                 state_r;
  logic [CMP_WIDTH-1:0]   op_a_r;
  logic [CMP_WIDTH-1:0]   op_b_r;
  logic [IDX_W-1:0]       k_r;
  logic [2:0]             first_diff_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [DIGIT_WIDTH-1:0] dig_a_s;
  logic [DIGIT_WIDTH-1:0] dig_b_s;
  logic [2:0]             cmp_s;
  logic                   finish_s;
  logic [2:0]             result_s;

  assign dig_a_s = op_a_r[k_r*DIGIT_WIDTH +: DIGIT_WIDTH];
  assign dig_b_s = op_b_r[k_r*DIGIT_WIDTH +: DIGIT_WIDTH];

  digit_compare #(
    .DIGIT_WIDTH(DIGIT_WIDTH)
  ) u_digit_compare (
    .x   (dig_a_s),
    .y   (dig_b_s),
    .code(cmp_s)
  );

  // Decide whether this scan step is the last one and which result it reports.
  always_comb begin
    finish_s = 1'b0;
    result_s = cmp_s;
    if (EARLY_EXIT && (cmp_s != CMP_EQ)) begin
      finish_s = 1'b1;
    end else if (k_r == IDX_ZERO) begin
      finish_s = 1'b1;
      result_s = (first_diff_r != CMP_NONE) ? first_diff_r : cmp_s;
    end else begin
      finish_s = 1'b0;
    end
  end

  // Handshake FSM, operand capture and registered result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      op_a_r       <= OP_ZERO;
      op_b_r       <= OP_ZERO;
      k_r          <= IDX_ZERO;
      first_diff_r <= CMP_NONE;
      cnt_r        <= CNT_ZERO;
      busy         <= 1'b0;
      done         <= 1'b0;
      greater      <= 1'b0;
      equal        <= 1'b0;
      smaller      <= 1'b0;
      digits_used  <= CNT_ZERO;
    end else begin
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            // Flipping the sign bit maps two's complement onto offset binary.
            op_a_r       <= a ^ (signed_mode ? SIGN_MASK : OP_ZERO);
            op_b_r       <= b ^ (signed_mode ? SIGN_MASK : OP_ZERO);
            k_r          <= IDX_TOP;
            first_diff_r <= CMP_NONE;
            cnt_r        <= CNT_ZERO;
            busy         <= 1'b1;
            state_r      <= SCAN;
          end else begin
            state_r <= IDLE;
          end
        end
        SCAN: begin
          cnt_r <= cnt_r + CNT_ONE;
          if (finish_s) begin
            {greater, equal, smaller} <= result_s;
            digits_used               <= cnt_r + CNT_ONE;
            done                      <= 1'b1;
            busy                      <= 1'b0;
            state_r                   <= IDLE;
          end else begin
            k_r <= k_r - IDX_ONE;
            if ((first_diff_r == CMP_NONE) && (cmp_s != CMP_EQ)) begin
              first_diff_r <= cmp_s;
            end else begin
              first_diff_r <= first_diff_r;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_compare_serial_n.sv
// Directed self-checking bench: default early-exit instance plus a fixed-latency instance.
module tb_compare_serial_n;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       signed_mode = 1'b0;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;

  logic       busy0, done0, gt0, eq0, lt0;
  logic [2:0] used0;
  logic       busy1, done1, gt1, eq1, lt1;
  logic [2:0] used1;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  compare_serial_n #(.CMP_WIDTH(8), .DIGIT_WIDTH(2), .EARLY_EXIT(1'b1)) dut0 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy0), .done(done0), .greater(gt0), .equal(eq0), .smaller(lt0), .digits_used(used0)
  );

  compare_serial_n #(.CMP_WIDTH(8), .DIGIT_WIDTH(2), .EARLY_EXIT(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode), .a(a), .b(b),
    .busy(busy1), .done(done1), .greater(gt1), .equal(eq1), .smaller(lt1), .digits_used(used1)
  );

  // Pulse start for one edge, then count edges until the selected instance raises done.
  task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic sm,
                        input bit sel, output int cycles);
    @(negedge clk);
    a = va; b = vb; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (((sel ? done1 : done0) !== 1'b1) && (cycles < 20)) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy0, done0, gt0, eq0, lt0, used0} !== 8'h00) begin
      bad++; $display("FAIL reset_dut0 got=%b want=00000000", {busy0, done0, gt0, eq0, lt0, used0});
    end
    total++;
    if ({busy1, done1, gt1, eq1, lt1, used1} !== 8'h00) begin
      bad++; $display("FAIL reset_dut1 got=%b want=00000000", {busy1, done1, gt1, eq1, lt1, used1});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_early_exit;
    run_op(8'hA5, 8'h25, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 1 || {gt0, eq0, lt0} !== 3'b100 || used0 !== 3'd1) begin
      bad++; $display("FAIL a5_vs_25 lat=%0d flags=%b used=%0d want lat=1 flags=100 used=1", lat, {gt0, eq0, lt0}, used0);
    end
    @(posedge clk); #1;
    total++;
    if (done0 !== 1'b0) begin
      bad++; $display("FAIL done_one_cycle got=%b want=0", done0);
    end
    run_op(8'h3C, 8'h3C, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4 || {gt0, eq0, lt0} !== 3'b010 || used0 !== 3'd4) begin
      bad++; $display("FAIL 3c_vs_3c lat=%0d flags=%b used=%0d want lat=4 flags=010 used=4", lat, {gt0, eq0, lt0}, used0);
    end
    run_op(8'h3D, 8'h3C, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4 || {gt0, eq0, lt0} !== 3'b100 || used0 !== 3'd4) begin
      bad++; $display("FAIL 3d_vs_3c lat=%0d flags=%b used=%0d want lat=4 flags=100 used=4", lat, {gt0, eq0, lt0}, used0);
    end
  endtask

  task automatic test_signed;
    run_op(8'h80, 8'h7F, 1'b1, 1'b0, lat);
    total++;
    if ({gt0, eq0, lt0} !== 3'b001 || used0 !== 3'd1) begin
      bad++; $display("FAIL signed_80_7f flags=%b used=%0d want flags=001 used=1", {gt0, eq0, lt0}, used0);
    end
    run_op(8'h80, 8'h7F, 1'b0, 1'b0, lat);
    total++;
    if ({gt0, eq0, lt0} !== 3'b100 || used0 !== 3'd1) begin
      bad++; $display("FAIL unsigned_80_7f flags=%b used=%0d want flags=100 used=1", {gt0, eq0, lt0}, used0);
    end
    run_op(8'hFF, 8'hFE, 1'b1, 1'b0, lat);
    total++;
    if ({gt0, eq0, lt0} !== 3'b100 || used0 !== 3'd4) begin
      bad++; $display("FAIL signed_ff_fe flags=%b used=%0d want flags=100 used=4", {gt0, eq0, lt0}, used0);
    end
  endtask

  task automatic test_fixed_latency;
    int busy_cnt;
    @(negedge clk);
    a = 8'hC0; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_cnt = 0;
    while ((done1 !== 1'b1) && (lat < 20)) begin
      if (busy1 === 1'b1) busy_cnt++;
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 4 || busy_cnt !== 4 || {gt1, eq1, lt1} !== 3'b100 || used1 !== 3'd4) begin
      bad++; $display("FAIL fixed_c0_00 lat=%0d busy=%0d flags=%b used=%0d want 4 4 100 4", lat, busy_cnt, {gt1, eq1, lt1}, used1);
    end
    // The first difference (upper digit, A bigger) must win over later digits where B is bigger.
    run_op(8'h40, 8'h3F, 1'b0, 1'b1, lat);
    total++;
    if (lat !== 4 || {gt1, eq1, lt1} !== 3'b100 || used1 !== 3'd4) begin
      bad++; $display("FAIL fixed_40_3f lat=%0d flags=%b used=%0d want 4 100 4", lat, {gt1, eq1, lt1}, used1);
    end
    run_op(8'h01, 8'h02, 1'b0, 1'b1, lat);
    total++;
    if (lat !== 4 || {gt1, eq1, lt1} !== 3'b001 || used1 !== 3'd4) begin
      bad++; $display("FAIL fixed_01_02 lat=%0d flags=%b used=%0d want 4 001 4", lat, {gt1, eq1, lt1}, used1);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    a = 8'h10; b = 8'h20; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF; b = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'h00; b = 8'h00;
    lat = 1;
    while ((done0 !== 1'b1) && (lat < 20)) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 2 || {gt0, eq0, lt0} !== 3'b001 || used0 !== 3'd2) begin
      bad++; $display("FAIL busy_start_ignored lat=%0d flags=%b used=%0d want 2 001 2", lat, {gt0, eq0, lt0}, used0);
    end
    a = 8'h22; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    total++;
    if (busy0 !== 1'b1 || {gt0, eq0, lt0} !== 3'b001) begin
      bad++; $display("FAIL done_cycle_start busy=%b flags=%b want busy=1 flags=001", busy0, {gt0, eq0, lt0});
    end
    lat = 0;
    while ((done0 !== 1'b1) && (lat < 20)) begin
      @(posedge clk); #1;
      lat++;
    end
    total++;
    if (lat !== 2 || {gt0, eq0, lt0} !== 3'b100 || used0 !== 3'd2) begin
      bad++; $display("FAIL back_to_back_22_11 lat=%0d flags=%b used=%0d want 2 100 2", lat, {gt0, eq0, lt0}, used0);
    end
  endtask

  task automatic test_reset_mid_scan;
    int done_seen;
    @(negedge clk);
    a = 8'h00; b = 8'h00; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    total++;
    if ({busy0, done0, gt0, eq0, lt0, used0} !== 8'h00) begin
      bad++; $display("FAIL async_reset got=%b want=00000000", {busy0, done0, gt0, eq0, lt0, used0});
    end
    @(negedge clk);
    rst = 1'b0;
    done_seen = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done0 === 1'b1) done_seen++;
    end
    total++;
    if (done_seen !== 0 || busy0 !== 1'b0) begin
      bad++; $display("FAIL no_done_after_reset dones=%0d busy=%b want 0 0", done_seen, busy0);
    end
    run_op(8'h5A, 8'h5A, 1'b0, 1'b0, lat);
    total++;
    if (lat !== 4 || {gt0, eq0, lt0} !== 3'b010 || used0 !== 3'd4) begin
      bad++; $display("FAIL after_reset_5a lat=%0d flags=%b used=%0d want 4 010 4", lat, {gt0, eq0, lt0}, used0);
    end
  endtask

  initial begin
    test_reset;
    test_early_exit;
    test_signed;
    test_fixed_latency;
    test_back_to_back;
    test_reset_mid_scan;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/compare_serial_n.md
Name: compare_serial_n

Overview:
Parametrised, digit-serial magnitude comparator with a start/busy/done handshake. It is the sequential successor to the combinational width-parametrised comparator. It scans the operands MSB-first, DIGIT_WIDTH bits per cycle, and adds a signed mode and optional early exit on the first differing digit. It sits beside datapath blocks that need wide compares without a wide single-cycle comparator on the critical path.

Parameters:
CMP_WIDTH, 8, operand width in bits; must be >= 2.
DIGIT_WIDTH, 2, bits compared per cycle; must divide CMP_WIDTH exactly. NUM_DIGITS = CMP_WIDTH/DIGIT_WIDTH.
EARLY_EXIT, 1, 1 = finish on the first differing digit; 0 = always scan all NUM_DIGITS digits (fixed latency).

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous reset, active-high.
start  input  1  request; sampled only when busy=0.
signed_mode  input  1  1 = two's-complement compare; captured with start.
a  input  CMP_WIDTH  operand A; captured with start.
b  input  CMP_WIDTH  operand B; captured with start.
busy  output  1  high while a scan is in progress.
done  output  1  one-cycle pulse when the result is valid.
greater  output  1  A > B (registered).
equal  output  1  A == B (registered).
smaller  output  1  A < B (registered).
digits_used  output  clog2(NUM_DIGITS+1)  number of digits examined for the last result.

Behaviour:
- Reset: state=IDLE. busy, done, greater, equal, smaller and digits_used are all 0. Reset applies immediately and asynchronously.
- States: IDLE and SCAN. All outputs are registered.
- IDLE, start=1 at an edge:
  - Capture a and b into opA and opB.
  - If signed_mode=1, invert the MSB of both captured operands (offset-binary), so an unsigned scan gives the signed result.
  - Set digit index k=NUM_DIGITS-1, first-difference register=none, digit counter=0, busy=1. Go to SCAN.
- SCAN, each edge: compare digit k of opA and opB (bits k*DW+DW-1 .. k*DW) unsigned, and increment the counter.
  - EARLY_EXIT=1 and the digits differ: register the result from this digit and finish.
  - Digits equal and k=0: finish; the result is equal, or the stored first difference when EARLY_EXIT=0.
  - Otherwise: k=k-1. When EARLY_EXIT=0, store the first difference only if none is stored yet.
- Finish edge:
  - {greater,equal,smaller} are updated, exactly one-hot.
  - digits_used = digits examined.
  - done=1 for exactly one cycle, busy=0, state returns to IDLE.
- Latency:
  - The done cycle follows the start edge by D cycles, where D = digits examined.
  - EARLY_EXIT=1: D is 1..NUM_DIGITS.
  - EARLY_EXIT=0: D = NUM_DIGITS always.
- Result flags hold their value until the next finish edge; they are not cleared by start. Before the first result after reset they are 000.
- start while busy=1 is ignored; operands and the scan are unaffected.
- start during the done cycle (busy=0) is accepted, giving back-to-back operation with no idle cycle.
- a, b and signed_mode may change freely after the capture edge without effect.
- Reset mid-SCAN: the operation is abandoned, outputs go to reset values immediately, and no done pulse follows reset release.
- NUM_DIGITS=1 is legal: single-cycle compare, D=1.

Decomposition:
- Shared package compare_pkg holds:
  - state enum {IDLE, SCAN};
  - 3-bit result encoding {gt,eq,lt} with constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001;
  - helper function for NUM_DIGITS and the counter width.
- One sub-module, digit_compare: combinational, parameter DIGIT_WIDTH, inputs x and y, output a 3-bit {gt,eq,lt} code. Instantiate it once on the muxed digit k.
- Parameter legality (divisibility, CMP_WIDTH>=2) is checked by an elaboration-time assertion.

Test Plan:
1. Defaults (8/2/1), unsigned: a=0xA5, b=0x25. Required: done 1 cycle after the start edge, greater=1, digits_used=1.
2. a=0x3C, b=0x3C. Required: done 4 cycles after start, equal=1, digits_used=4. Also a=0x3D, b=0x3C: smaller=0, greater=1, digits_used=4.
3. a=0x80, b=0x7F.
   - signed_mode=1: smaller=1, digits_used=1.
   - signed_mode=0: greater=1.
   - a=0xFF (-1), b=0xFE (-2), signed: greater=1, digits_used=4.
4. EARLY_EXIT=0: a=0xC0, b=0x00. Required: greater=1, done exactly 4 cycles after start, digits_used=4, busy high for 4 cycles.
5. Handshake:
   - Start with a=0x10, b=0x20, then assert start with a=0xFF, b=0x00 while busy. The second start is ignored; result is smaller=1.
   - Assert start in the done cycle with a=0x22, b=0x11. It is accepted; the next done reports greater=1.
6. Assert rst asynchronously mid-SCAN, between clock edges. Required: busy, done and flags go to 0 before the next edge; no done pulse after release; a fresh start then completes normally.
